gt_sweep_checker: RTL and testbench
===================================

# gt_sweep_checker

Self-checking exhaustive sweep engine for W-bit greater-than comparators: on a start request it drives every (a, b) operand pair into a comparator under test, holds each pair for a settle window, samples the comparator's agtb response, and compares it against a built-in golden a > b. It sits beside the comparator on the FPGA board, turning the simulation-only exhaustive sweep into a synthesizable on-chip checker with a start/done handshake and an error count for LEDs or a status register.

## Interface
- W, default 4: operand width. Vector space is 2^(2W).
- SETTLE, default 2: extra cycles each vector is held before its sample cycle, 0..15.
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- start, input, 1: sweep request, sampled only in IDLE.
- agtb_in, input, 1: response from the comparator under test.
- a, output, W: operand A driven to the comparator under test.
- b, output, W: operand B driven to the comparator under test.
- busy, output, 1: high while the sweep runs.
- done, output, 1: one-cycle pulse at sweep completion.
- pass, output, 1: high when the last sweep had zero mismatches; held until the next start.
- err_cnt, output, 2W+1: mismatch count of the current or last sweep.
- fail_valid, output, 1: first-fail capture valid.
- fail_a, output, W: A value of the first mismatch.
- fail_b, output, W: B value of the first mismatch.
- fail_got, output, 1: agtb_in value at the first mismatch.

## Operation
- Reset values: a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, fail_a=0, fail_b=0, fail_got=0. State is IDLE.
- FSM states: IDLE, HOLD, DONE.
  - **IDLE:** when start=1, go to HOLD. Load a=0, b=0 and settle counter=SETTLE. Clear err_cnt, pass and all fail_* outputs. Set busy=1.
  - **HOLD:** while the counter is nonzero, decrement it. When the counter is 0, that cycle is the sample cycle.
  - **Sample cycle:** compare agtb_in against (a > b), unsigned. On mismatch, err_cnt increments.
  - **After the sample, on the last vector** (a=all-ones and b=all-ones): go to DONE.
  - **After the sample, otherwise:** advance the vector and reload the counter with SETTLE.
- Sweep order: b is the outer loop and a is the inner loop. The sequence is (a,b) = (0,0), (1,0), …, (2^W−1, 0), (0,1), and so on. a wraps to 0 while b increments.
- DONE: done=1 for exactly one cycle, busy=0, pass=(err_cnt==0). Then return to IDLE. a and b hold their final values until the next start.
- start is ignored while busy or in DONE. No queuing.
- err_cnt cannot overflow: its maximum is 2^(2W), which fits in 2W+1 bits.
- Reset asserted mid-sweep: all outputs return to reset values immediately. A partial result is never reported.

## Timing
- start is seen high at edge T. busy=1 and (a,b)=(0,0) from T onward.
- Vector k is driven from edge T+k·(SETTLE+1). It is sampled at edge T+k·(SETTLE+1)+SETTLE.
- done rises at edge T+2^(2W)·(SETTLE+1) and is high for one cycle. For W=4 and SETTLE=2 that is T+768.
- busy falls and pass/err_cnt become final at the same edge that done rises.
- agtb_in is treated as combinational from a and b. The settle window absorbs up to SETTLE register stages in the path under test.

## Configuration
- GT_SWEEP_FIRST_FAIL_EN
  - **Defined:** on the first mismatch of a sweep, capture fail_a=a, fail_b=b, fail_got=agtb_in and set fail_valid=1. Later mismatches do not overwrite the capture. The capture is cleared on start or reset. The sweep always runs to completion.
  - **Undefined:** fail_valid, fail_a, fail_b and fail_got are tied to 0, and no capture registers are built.

## Structure
- Package gt_sweep_pkg holds:
  - the FSM state enum (IDLE, HOLD, DONE);
  - the default W and SETTLE localparams;
  - a golden function gt_ref(a, b) returning a > b.
- Sub-module gt_sweep_gen holds the vector counter and settle counter. It outputs a, b, sample strobe and last flag. The top level owns the FSM, the compare, err_cnt and the fail capture.

## Test plan
- **Correct comparator** (agtb_in = a>b), W=4, SETTLE=2, start pulse at T: done at T+768, pass=1, err_cnt=0, fail_valid=0.
- **Stuck-at-0 response:** err_cnt=120, pass=0. With the macro defined, fail_a=1, fail_b=0, fail_got=0.
- **Stuck-at-1 response:** err_cnt=136, pass=0. With the macro defined, fail_a=0, fail_b=0, fail_got=1.
- **Response = a>=b:** err_cnt=16, one per a==b pair. With the macro defined, fail_a=0, fail_b=0, fail_got=1.
- **start re-pulsed at T+100 during a sweep:** ignored. done still at T+768 with one pulse only. A second start after done clears err_cnt and pass and reruns the sweep.
- **reset_n low at T+300 during a sweep:** outputs return to reset values immediately. No done pulse. After release, a fresh start completes normally.

Source files
------------

// File: rtl/gt_sweep_pkg.sv
// Shared types, defaults and the golden reference for the greater-than sweep checker.
package gt_sweep_pkg;

    localparam int GT_W_DEFAULT      = 4;
    localparam int GT_SETTLE_DEFAULT = 2;
    // Width of the settle counter; SETTLE is limited to 0..15.
    localparam int GT_CNT_W          = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Golden unsigned greater-than. Operands are zero-extended by the caller.
    function automatic logic gt_ref(input logic [31:0] x, input logic [31:0] y);
        return x > y;
    endfunction

endpackage

// File: rtl/gt_sweep_gen.sv
// Vector and settle-window generator for the sweep checker.
// The operand pair is one 2W-bit counter: a is the low half (inner loop),
// b is the high half (outer loop). Each vector is held SETTLE extra cycles.
module gt_sweep_gen
    import gt_sweep_pkg::*;
#(
    parameter int W      = GT_W_DEFAULT,
    parameter int SETTLE = GT_SETTLE_DEFAULT
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         run,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         sample,
    output logic         last
);

    logic [2*W-1:0]      vec;
    logic [GT_CNT_W-1:0] cnt;

    assign a      = vec[W-1:0];
    assign b      = vec[2*W-1:W];
    assign last   = &vec;
    assign sample = run && (cnt == '0);

    // Count down the settle window, then step to the next vector.
    // The final vector is held until the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vec <= '0;
            cnt <= '0;
        end else if (load) begin
            vec <= '0;
            cnt <= GT_CNT_W'(SETTLE);
        end else if (run) begin
            if (cnt != '0) begin
                cnt <= cnt - GT_CNT_W'(1);
            end else if (!last) begin
                vec <= vec + (2*W)'(1);
                cnt <= GT_CNT_W'(SETTLE);
            end
        end
    end

endmodule

// File: rtl/gt_sweep_checker.sv
// Exhaustive on-chip sweep checker for a W-bit greater-than comparator.
// Optional first-fail capture is built only when GT_SWEEP_FIRST_FAIL_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; last result held on pass/err_cnt/fail_*
// HOLD  | sweep running; vectors driven, sampled after each settle window
// DONE  | one-cycle completion pulse; result final
module gt_sweep_checker
    import gt_sweep_pkg::*;
#(
    parameter int W      = GT_W_DEFAULT,
    parameter int SETTLE = GT_SETTLE_DEFAULT
)
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         agtb_in,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [2*W:0] err_cnt,
    output logic         fail_valid,
    output logic [W-1:0] fail_a,
    output logic [W-1:0] fail_b,
    output logic         fail_got
);

    localparam int ERR_W = 2*W + 1;

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             run;
    logic             sample;
    logic             last;
    logic             golden;
    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;

    gt_sweep_gen #(
        .W      (W),
        .SETTLE (SETTLE)
    ) u_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .run     (run),
        .a       (a),
        .b       (b),
        .sample  (sample),
        .last    (last)
    );

    assign run      = (state == HOLD);
    assign busy     = (state == HOLD);
    assign done     = (state == DONE);
    assign golden   = gt_ref(32'(a), 32'(b));
    assign mismatch = sample && (agtb_in != golden);
    assign err_nxt  = mismatch ? (err_cnt + ERR_W'(1)) : err_cnt;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = HOLD;
                    load      = 1'b1;
                end
            end
            HOLD: begin
                if (sample && last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Mismatch count and verdict; pass becomes final on the edge that enters DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
            pass    <= 1'b0;
        end else if (load) begin
            err_cnt <= '0;
            pass    <= 1'b0;
        end else begin
            err_cnt <= err_nxt;
            if (sample && last) begin
                pass <= (err_nxt == '0);
            end
        end
    end

`ifdef GT_SWEEP_FIRST_FAIL_EN
    // Capture only the first mismatch of a sweep.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_got   <= 1'b0;
        end else if (load) begin
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            fail_got   <= 1'b0;
        end else if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= a;
            fail_b     <= b;
            fail_got   <= agtb_in;
        end
    end
`else
    assign fail_valid = 1'b0;
    assign fail_a     = '0;
    assign fail_b     = '0;
    assign fail_got   = 1'b0;
`endif

endmodule

// File: tb/tb_gt_sweep_checker.sv
// Directed bench for gt_sweep_checker (W=4, SETTLE=2). The comparator under
// test is a behavioural response selected by mode; expected sweep results are
// pushed to a scoreboard at start and popped when done pulses.
module tb_gt_sweep_checker;

    localparam int W   = 4;
    localparam int S   = 2;
    localparam int NV  = 1 << (2*W);
    localparam int LAT = NV * (S + 1);

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic           agtb_in;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic           pass;
    logic [2*W:0]   err_cnt;
    logic           fail_valid;
    logic [W-1:0]   fail_a;
    logic [W-1:0]   fail_b;
    logic           fail_got;

    int mode     = 0;
    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    typedef struct {
        int   err;
        logic pass;
        logic fv;
        int   fa;
        int   fb;
        logic fg;
    } exp_t;

    exp_t sb[$];

    gt_sweep_checker #(.W(W), .SETTLE(S)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .agtb_in    (agtb_in),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_valid (fail_valid),
        .fail_a     (fail_a),
        .fail_b     (fail_b),
        .fail_got   (fail_got)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator under test: 0 correct, 1 stuck-at-0, 2 stuck-at-1, 3 a>=b.
    function automatic logic resp(input int m, input logic [W-1:0] x, input logic [W-1:0] y);
        case (m)
            0:       return x > y;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return x >= y;
        endcase
    endfunction

    assign agtb_in = resp(mode, a, b);

    // Expected result after the first n vectors of a sweep in (a inner, b outer) order.
    function automatic exp_t build(input int m, input int n);
        exp_t       e;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic       got;
        e.err = 0; e.fv = 1'b0; e.fa = 0; e.fb = 0; e.fg = 1'b0;
        for (int k = 0; k < n; k++) begin
            x   = W'(k % (1 << W));
            y   = W'(k / (1 << W));
            got = resp(m, x, y);
            if (got != (x > y)) begin
                e.err++;
                if (!e.fv) begin
                    e.fv = 1'b1; e.fa = int'(x); e.fb = int'(y); e.fg = got;
                end
            end
        end
        e.pass = (e.err == 0);
`ifndef GT_SWEEP_FIRST_FAIL_EN
        e.fv = 1'b0; e.fa = 0; e.fb = 0; e.fg = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_a"}, 32'(a), 0);
        chk({p, "_b"}, 32'(b), 0);
        chk({p, "_busy"}, 32'(busy), 0);
        chk({p, "_done"}, 32'(done), 0);
        chk({p, "_pass"}, 32'(pass), 0);
        chk({p, "_err"}, 32'(err_cnt), 0);
        chk({p, "_fv"}, 32'(fail_valid), 0);
        chk({p, "_fa"}, 32'(fail_a), 0);
        chk({p, "_fb"}, 32'(fail_b), 0);
        chk({p, "_fg"}, 32'(fail_got), 0);
    endtask

    // One-cycle start pulse; t is the index of the edge that saw start high.
    task automatic start_pulse(output int t);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = cyc;
    endtask

    task automatic run_sweep(input int m, input bit repulse);
        int   t;
        int   tdone;
        bit   seen;
        exp_t e;
        mode = m;
        sb.push_back(build(m, NV));
        start_pulse(t);
        chk("start_busy", 32'(busy), 1);
        chk("start_a", 32'(a), 0);
        chk("start_b", 32'(b), 0);
        chk("start_err", 32'(err_cnt), 0);
        chk("start_pass", 32'(pass), 0);
        chk("start_fv", 32'(fail_valid), 0);
        seen  = 1'b0;
        tdone = 0;
        while (!seen && cyc < t + LAT + 200) begin
            @(negedge clk);
            start = repulse && (cyc == t + 99);
            if (cyc == t + 17*(S+1)) begin
                chk("vec17_a", 32'(a), 1);
                chk("vec17_b", 32'(b), 1);
            end
            if (cyc == t + 255*(S+1)) begin
                chk("vec255_a", 32'(a), 15);
                chk("vec255_b", 32'(b), 15);
                chk("vec255_busy", 32'(busy), 1);
            end
            if (done) begin
                seen  = 1'b1;
                tdone = cyc;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_time", 32'(tdone - t), LAT);
            chk("done_busy", 32'(busy), 0);
            chk("done_err", 32'(err_cnt), 32'(e.err));
            chk("done_pass", 32'(pass), 32'(e.pass));
            chk("done_fv", 32'(fail_valid), 32'(e.fv));
            chk("done_fa", 32'(fail_a), 32'(e.fa));
            chk("done_fb", 32'(fail_b), 32'(e.fb));
            chk("done_fg", 32'(fail_got), 32'(e.fg));
            @(negedge clk);
            chk("done_pulse", 32'(done), 0);
            chk("hold_pass", 32'(pass), 32'(e.pass));
            chk("hold_err", 32'(err_cnt), 32'(e.err));
            chk("hold_a", 32'(a), 15);
            chk("hold_b", 32'(b), 15);
        end
    endtask

    initial begin
        int   t;
        exp_t part;
        bit   spurious;
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        reset_n = 1'b1;
        @(negedge clk);
        chk_reset("rel");

        run_sweep(1, 1'b0);   // stuck-at-0: 120 errors
        run_sweep(0, 1'b1);   // correct, with ignored re-start at T+100
        run_sweep(2, 1'b0);   // stuck-at-1: 136 errors
        run_sweep(3, 1'b0);   // a>=b: 16 errors

        // Reset in the middle of a stuck-at-0 sweep.
        mode = 1;
        sb.push_back(build(1, NV));
        start_pulse(t);
        while (cyc < t + 300) @(negedge clk);
        part = build(1, 100);
        chk("mid_err", 32'(err_cnt), 32'(part.err));
        chk("mid_busy", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        chk_reset("midrst");
        sb.delete();
        spurious = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) spurious = 1'b1;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done) spurious = 1'b1;
        end
        chk("no_done_after_rst", 32'(spurious), 0);
        chk_reset("postrst");

        run_sweep(0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
